// File: rtl/irq_priority_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_priority_controller
// Description : Bus-mapped interrupt controller. Edge-latches up to 8 source
//               requests, masks them, raises the highest-priority one (source
//               0 highest) to the processor and holds it through ACK and the
//               service routine until software writes end-of-interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_priority_controller #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         NUM_SRC   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    inout  wire  [7:0]         bus_data_io,
    input  logic [7:0]         bus_addr_i,
    input  logic               bus_we_i,
    input  logic [NUM_SRC-1:0] src_irq_i,
    output logic               cpu_irq_raise_o,
    input  logic               cpu_irq_ack_i
);

    // Register offsets from BASE_ADDR
    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_MASK    = 3'd1;
    localparam logic [2:0] OFF_VECTOR  = 3'd2;
    localparam logic [2:0] OFF_EOI     = 3'd3;
    localparam logic [2:0] OFF_SOFTSET = 3'd4;

    // Bits at or above NUM_SRC are forced to zero in PENDING and MASK
    localparam logic [7:0] SRC_BITS = 8'((16'd1 << NUM_SRC) - 16'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISE   = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e             state_q;
    logic [2:0]         active_idx_q;
    logic               raise_q;
    logic [NUM_SRC-1:0] src_q;
    logic [7:0]         pending_q, pending_d;
    logic [7:0]         mask_q, mask_d;
    logic               rd_en_q;
    logic [7:0]         rd_data_q;

    logic [8:0]         addr_off;
    logic               addr_hit;
    logic [2:0]         off;
    logic [7:0]         wdata;
    logic               wr_pending, wr_mask, wr_eoi, wr_softset;
    logic [7:0]         rise;
    logic [7:0]         enabled;
    logic [2:0]         arb_idx;
    logic               ack_take;
    logic [7:0]         clr_vec, set_vec;
    logic [7:0]         rd_mux;

    // 9-bit subtraction: addresses below BASE wrap to >= 256 and miss
    assign addr_off   = {1'b0, bus_addr_i} - {1'b0, BASE_ADDR};
    assign addr_hit   = (addr_off <= 9'd4);
    assign off        = addr_off[2:0];
    assign wdata      = bus_data_io;

    assign wr_pending = bus_we_i && addr_hit && (off == OFF_PENDING);
    assign wr_mask    = bus_we_i && addr_hit && (off == OFF_MASK);
    assign wr_eoi     = bus_we_i && addr_hit && (off == OFF_EOI);
    assign wr_softset = bus_we_i && addr_hit && (off == OFF_SOFTSET);

    assign rise       = 8'(src_irq_i & ~src_q);
    assign enabled    = pending_q & mask_q;
    assign ack_take   = (state_q == RAISE) && cpu_irq_ack_i;

    // Lowest enabled index wins; scan downward so the last hit is the lowest
    always_comb begin
        arb_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) arb_idx = 3'(i);
        end
    end

    // Clears are applied before sets so a same-cycle edge survives its clear
    always_comb begin
        clr_vec = 8'h00;
        set_vec = rise;
        if (wr_pending) clr_vec = wdata;
        if (ack_take)   clr_vec[active_idx_q] = 1'b1;
        if (wr_softset) set_vec = set_vec | wdata;
        pending_d = ((pending_q & ~clr_vec) | set_vec) & SRC_BITS;
        mask_d    = wr_mask ? (wdata & SRC_BITS) : mask_q;
    end

    // Readback mux of the register values present before the current edge
    always_comb begin
        case (off)
            OFF_PENDING: rd_mux = pending_q;
            OFF_MASK:    rd_mux = mask_q;
            OFF_VECTOR:  rd_mux = {(state_q == SERVICE), 4'b0000, active_idx_q};
            OFF_EOI:     rd_mux = {6'b000000, state_q};
            default:     rd_mux = 8'h00;
        endcase
    end

    // Source edge history plus PENDING and MASK storage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            src_q     <= '0;
            pending_q <= 8'h00;
            mask_q    <= 8'h00;
        end else begin
            src_q     <= src_irq_i;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Request/acknowledge/service sequencing with registered raise output
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            active_idx_q <= 3'd0;
            raise_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|enabled) begin
                        active_idx_q <= arb_idx;
                        raise_q      <= 1'b1;
                        state_q      <= RAISE;
                    end
                end
                RAISE: begin
                    if (cpu_irq_ack_i) begin
                        raise_q <= 1'b0;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    raise_q <= 1'b0;
                    if (wr_eoi) state_q <= IDLE;
                end
                default: begin
                    raise_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read port: capture on an addressed read, drive the bus for one cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_en_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            rd_en_q   <= !bus_we_i && addr_hit;
            rd_data_q <= rd_mux;
        end
    end

    assign bus_data_io     = rd_en_q ? rd_data_q : 8'hzz;
    assign cpu_irq_raise_o = raise_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_priority_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_priority_controller
// Description : Directed scoreboard bench for irq_priority_controller. Bus
//               reads and raise-line transitions are queued with hand-computed
//               values; a monitor pops and compares as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_priority_controller;

    localparam logic [7:0] A_PEND = 8'hE0;
    localparam logic [7:0] A_MASK = 8'hE1;
    localparam logic [7:0] A_VEC  = 8'hE2;
    localparam logic [7:0] A_EOI  = 8'hE3;
    localparam logic [7:0] A_SOFT = 8'hE4;
    localparam logic [7:0] A_IDLE = 8'h00;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } rd_exp_t;

    typedef struct {
        logic v;
        int   at;
    } rs_exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus_addr = A_IDLE;
    logic       bus_we = 1'b0;
    logic [3:0] src = 4'h0;
    logic       ack = 1'b0;
    logic       cpu_irq_raise;
    logic [7:0] tb_d = 8'h00;
    logic       tb_en = 1'b0;
    wire  [7:0] bus_data;

    assign bus_data = tb_en ? tb_d : 8'hzz;

    rd_exp_t rd_q[$];
    rs_exp_t rs_q[$];
    rd_exp_t rd_e;
    rs_exp_t rs_e;
    int      cyc = 0;
    int      total = 0;
    int      bad = 0;
    logic    rd_pending = 1'b0;
    logic    raise_prev = 1'b0;

    irq_priority_controller dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .bus_data_io     (bus_data),
        .bus_addr_i      (bus_addr),
        .bus_we_i        (bus_we),
        .src_irq_i       (src),
        .cpu_irq_raise_o (cpu_irq_raise),
        .cpu_irq_ack_i   (ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rd_pending <= rst_n && !bus_we && (bus_addr >= 8'hE0) && (bus_addr <= 8'hE4);
    end

    // Monitor: compares read data and raise transitions against the queues
    always @(negedge clk) begin
        if (rd_pending) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read got=%h", bus_data);
            end else begin
                rd_e = rd_q.pop_front();
                if (bus_data !== rd_e.v) begin
                    bad++;
                    $display("FAIL %s got=%h exp=%h", rd_e.nm, bus_data, rd_e.v);
                end
            end
        end
        if (cpu_irq_raise !== raise_prev) begin
            total++;
            if (rs_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_raise got=%b cyc=%0d", cpu_irq_raise, cyc);
            end else begin
                rs_e = rs_q.pop_front();
                if (cpu_irq_raise !== rs_e.v || cyc != rs_e.at) begin
                    bad++;
                    $display("FAIL raise_edge got=%b@%0d exp=%b@%0d",
                             cpu_irq_raise, cyc, rs_e.v, rs_e.at);
                end
            end
            raise_prev = cpu_irq_raise;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a; bus_we = 1'b1; tb_d = d; tb_en = 1'b1;
        tick();
        bus_we = 1'b0; tb_en = 1'b0; bus_addr = A_IDLE;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        rd_exp_t e;
        e.nm = nm; e.v = exp;
        rd_q.push_back(e);
        bus_addr = a;
        tick();
        bus_addr = A_IDLE;
        tick();
    endtask

    task automatic exp_raise(input logic v, input int at);
        rs_exp_t e;
        e.v = v; e.at = at;
        rs_q.push_back(e);
    endtask

    task automatic do_ack();
        exp_raise(1'b0, cyc + 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        rd(A_PEND, 8'h00, "rst_pending");
        rd(A_MASK, 8'h00, "rst_mask");
        rd(A_VEC,  8'h00, "rst_vector");
        rd(A_EOI,  8'h00, "rst_state");

        // 1: single source, full ACK/EOI cycle
        wr(A_MASK, 8'h0F);
        exp_raise(1'b1, cyc + 2);
        src = 4'b0100; tick(); src = 4'b0000; tick();
        rd(A_VEC,  8'h02, "t1_vector");
        rd(A_PEND, 8'h04, "t1_pending");
        rd(A_EOI,  8'h01, "t1_state_raise");
        do_ack();
        rd(A_PEND, 8'h00, "t1_pending_ack");
        rd(A_VEC,  8'h82, "t1_vector_srv");
        rd(A_EOI,  8'h02, "t1_state_srv");
        wr(A_EOI, 8'h00);
        rd(A_EOI,  8'h00, "t1_state_eoi");

        // 2: simultaneous edges, priority then queued second request
        exp_raise(1'b1, cyc + 2);
        src = 4'b1010; tick(); src = 4'b0000; tick();
        rd(A_VEC,  8'h01, "t2_vector_first");
        rd(A_PEND, 8'h0A, "t2_pending");
        do_ack();
        rd(A_PEND, 8'h08, "t2_pending_ack");
        exp_raise(1'b1, cyc + 2);
        wr(A_EOI, 8'h00);
        tick();
        rd(A_VEC,  8'h03, "t2_vector_second");
        do_ack();
        wr(A_EOI, 8'h00);
        rd(A_EOI,  8'h00, "t2_state_end");

        // 3: masked source latches but does not raise until enabled
        wr(A_MASK, 8'h00);
        src = 4'b0001; tick(); src = 4'b0000; tick();
        rd(A_PEND, 8'h01, "t3_pending_masked");
        rd(A_EOI,  8'h00, "t3_state_masked");
        exp_raise(1'b1, cyc + 2);
        wr(A_MASK, 8'h01);
        tick();
        rd(A_EOI,  8'h01, "t3_state_raise");
        rd(A_VEC,  8'h00, "t3_vector");
        do_ack();
        wr(A_EOI, 8'h00);

        // 4: reset while raising source 1
        wr(A_MASK, 8'h02);
        exp_raise(1'b1, cyc + 2);
        src = 4'b0010; tick(); src = 4'b0000; tick();
        rd(A_VEC,  8'h01, "t4_vector");
        exp_raise(1'b0, cyc + 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        rd(A_PEND, 8'h00, "t4_pending");
        rd(A_MASK, 8'h00, "t4_mask");
        rd(A_EOI,  8'h00, "t4_state");
        rd(A_VEC,  8'h00, "t4_vector_rst");

        // 5: SOFTSET, W1C, set-over-clear, stray ACK/EOI, write to VECTOR
        wr(A_SOFT, 8'h04);
        rd(A_PEND, 8'h04, "t5_softset");
        wr(A_PEND, 8'h04);
        rd(A_PEND, 8'h00, "t5_w1c");
        wr(A_SOFT, 8'h04);
        src = 4'b0100;
        wr(A_PEND, 8'h04);
        src = 4'b0000;
        rd(A_PEND, 8'h04, "t5_set_beats_clr");
        ack = 1'b1; tick(); ack = 1'b0;
        rd(A_PEND, 8'h04, "t5_ack_idle_pend");
        rd(A_EOI,  8'h00, "t5_ack_idle_state");
        wr(A_VEC, 8'hFF);
        rd(A_VEC,  8'h00, "t5_vector_ro");
        rd(A_MASK, 8'h00, "t5_mask_untouched");
        exp_raise(1'b1, cyc + 2);
        wr(A_MASK, 8'h04);
        tick();
        wr(A_EOI, 8'h00);
        rd(A_EOI,  8'h01, "t5_eoi_in_raise");
        do_ack();
        rd(A_VEC,  8'h82, "t5_vector_srv");
        rd(A_PEND, 8'h00, "t5_pending_ack");
        wr(A_EOI, 8'h00);
        rd(A_EOI,  8'h00, "t5_state_end");

        // 6: level held high requests only once
        wr(A_MASK, 8'h02);
        exp_raise(1'b1, cyc + 2);
        src = 4'b0010;
        tick(); tick();
        do_ack();
        wr(A_EOI, 8'h00);
        repeat (95) tick();
        src = 4'b0000;
        tick(); tick();
        rd(A_PEND, 8'h00, "t6_pending");
        rd(A_EOI,  8'h00, "t6_state");
        repeat (5) tick();

        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL reads_left got=%0d exp=0", rd_q.size());
        end
        total++;
        if (rs_q.size() != 0) begin
            bad++;
            $display("FAIL raise_events_left got=%0d exp=0", rs_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
